// File: rtl/phy_link_ctrl.sv
// Link-management FSM for the multi-lane PHY datapath: sequences RESET/INIT/IDLE/ACTIVE/ERROR,
// owns the FIFO almost-full/almost-empty thresholds and drives per-lane pause.
module phy_link_ctrl #(
  parameter int DEPTH_W     = 3,
  parameter int INIT_CYCLES = 4,
  parameter int AF_DEFAULT  = 6,
  parameter int AE_DEFAULT  = 1,
  parameter int NUM_LANES   = 4
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  input  logic                 init,
  input  logic [DEPTH_W-1:0]   cfg_af_in,
  input  logic [DEPTH_W-1:0]   cfg_ae_in,
  input  logic [NUM_LANES-1:0] fifo_empty,
  input  logic [NUM_LANES-1:0] fifo_almost_full,
  input  logic [NUM_LANES-1:0] fifo_error,
  output logic [DEPTH_W-1:0]   cfg_af_out,
  output logic [DEPTH_W-1:0]   cfg_ae_out,
  output logic [NUM_LANES-1:0] pause,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic [NUM_LANES-1:0] error_lanes,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INIT_CYCLES);

  state_e               st, ns;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [DEPTH_W-1:0]   af_n, ae_n;
  logic [NUM_LANES-1:0] pause_n, lanes_n;
  logic                 idle_n, act_n, err_n;
  logic                 thr_ok;

  assign thr_ok = (cfg_ae_out < cfg_af_out) && (cfg_af_out != '0);
  assign state  = st;

  always_comb begin
    ns      = st;
    cnt_n   = cnt;
    af_n    = cfg_af_out;
    ae_n    = cfg_ae_out;
    pause_n = '1;
    lanes_n = error_lanes;
    idle_n  = 1'b0;
    act_n   = 1'b0;
    err_n   = 1'b0;

    case (st)
      ST_RESET: begin
        ns    = ST_INIT;
        cnt_n = '0;
      end
      ST_INIT: begin
        if (init) begin
          af_n = cfg_af_in;
          ae_n = cfg_ae_in;
        end
        cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        // Leave on the edge that completes the INIT_CYCLES-th cycle in INIT.
        if (!init && cnt_n == CNT_MAX && thr_ok) ns = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (|fifo_error) ns = ST_ERROR;
        else if (init) begin
          ns    = ST_INIT;
          cnt_n = '0;
        end
        else if (st == ST_IDLE && fifo_empty != '1) ns = ST_ACTIVE;
        else if (st == ST_ACTIVE && fifo_empty == '1) ns = ST_IDLE;
      end
      ST_ERROR: ns = ST_ERROR;
      default: begin
        ns    = ST_RESET;
        cnt_n = '0;
      end
    endcase

    // Moore outputs are computed from the next state so they land with it.
    case (ns)
      ST_IDLE: begin
        idle_n  = 1'b1;
        pause_n = fifo_almost_full;
      end
      ST_ACTIVE: begin
        act_n   = 1'b1;
        pause_n = fifo_almost_full;
      end
      ST_ERROR: begin
        err_n   = 1'b1;
        lanes_n = error_lanes | fifo_error;
      end
      ST_RESET: lanes_n = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      st          <= ST_RESET;
      cnt         <= '0;
      cfg_af_out  <= DEPTH_W'(AF_DEFAULT);
      cfg_ae_out  <= DEPTH_W'(AE_DEFAULT);
      pause       <= '1;
      idle_out    <= 1'b0;
      active_out  <= 1'b0;
      error_out   <= 1'b0;
      error_lanes <= '0;
    end else begin
      st          <= ns;
      cnt         <= cnt_n;
      cfg_af_out  <= af_n;
      cfg_ae_out  <= ae_n;
      pause       <= pause_n;
      idle_out    <= idle_n;
      active_out  <= act_n;
      error_out   <= err_n;
      error_lanes <= lanes_n;
    end
  end

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed bench for phy_link_ctrl: bring-up timing, threshold loads, traffic, error and async reset.
module tb_phy_link_ctrl;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] cfg_af_in, cfg_ae_in;
  logic [3:0] fifo_empty, fifo_almost_full, fifo_error;
  logic [2:0] cfg_af_out, cfg_ae_out;
  logic [3:0] pause;
  logic       idle_out, active_out, error_out;
  logic [3:0] error_lanes;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  phy_link_ctrl dut (
    .clk_4f(clk_4f), .reset(reset), .init(init),
    .cfg_af_in(cfg_af_in), .cfg_ae_in(cfg_ae_in),
    .fifo_empty(fifo_empty), .fifo_almost_full(fifo_almost_full), .fifo_error(fifo_error),
    .cfg_af_out(cfg_af_out), .cfg_ae_out(cfg_ae_out), .pause(pause),
    .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
    .error_lanes(error_lanes), .state(state)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; cfg_af_in = 3'd0; cfg_ae_in = 3'd0;
    fifo_empty = 4'hF; fifo_almost_full = 4'h0; fifo_error = 4'h0;
    repeat (3) step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (pause !== 4'hF) begin errors++; $display("FAIL reset_pause: got %h expected f", pause); end
    checks++; if ({idle_out, active_out, error_out} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {idle_out, active_out, error_out}); end
    checks++; if (error_lanes !== 4'h0) begin errors++; $display("FAIL reset_lanes: got %h expected 0", error_lanes); end
    checks++; if ({cfg_af_out, cfg_ae_out} !== {3'd6, 3'd1}) begin errors++; $display("FAIL reset_thr: got %0d/%0d expected 6/1", cfg_af_out, cfg_ae_out); end
    reset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL bringup_init edge%0d: got %0d expected 1", e, state); end
      checks++; if (pause !== 4'hF) begin errors++; $display("FAIL bringup_pause edge%0d: got %h expected f", e, pause); end
    end
    step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL bringup_idle: got %0d expected 2", state); end
    checks++; if (idle_out !== 1'b1 || active_out !== 1'b0) begin errors++; $display("FAIL bringup_flags: got idle=%b active=%b expected 1/0", idle_out, active_out); end
    checks++; if (pause !== 4'h0) begin errors++; $display("FAIL bringup_pause_idle: got %h expected 0", pause); end
    checks++; if ({cfg_af_out, cfg_ae_out} !== {3'd6, 3'd1}) begin errors++; $display("FAIL bringup_thr: got %0d/%0d expected 6/1", cfg_af_out, cfg_ae_out); end
  endtask

  task automatic test_reinit();
    init = 1'b1; cfg_af_in = 3'd5; cfg_ae_in = 3'd2;
    step();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL reinit_enter: got %0d expected 1", state); end
    checks++; if (cfg_af_out !== 3'd6) begin errors++; $display("FAIL reinit_ignored_in_idle: got %0d expected 6", cfg_af_out); end
    checks++; if (idle_out !== 1'b0) begin errors++; $display("FAIL reinit_idle_low: got %b expected 0", idle_out); end
    step();
    checks++; if ({cfg_af_out, cfg_ae_out} !== {3'd5, 3'd2}) begin errors++; $display("FAIL reinit_load: got %0d/%0d expected 5/2", cfg_af_out, cfg_ae_out); end
    init = 1'b0; cfg_af_in = 3'd7; cfg_ae_in = 3'd0;
    step();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL reinit_cnt2: got %0d expected 1", state); end
    step();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL reinit_cnt3: got %0d expected 1", state); end
    step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL reinit_exit: got %0d expected 2", state); end
    checks++; if ({cfg_af_out, cfg_ae_out} !== {3'd5, 3'd2}) begin errors++; $display("FAIL reinit_hold: got %0d/%0d expected 5/2", cfg_af_out, cfg_ae_out); end
  endtask

  task automatic test_invalid_thr();
    init = 1'b1; cfg_af_in = 3'd2; cfg_ae_in = 3'd3;
    step(); step();
    init = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step();
      checks++; if (state !== 3'd1 || pause !== 4'hF) begin errors++; $display("FAIL invalid_stuck cyc%0d: got state=%0d pause=%h expected 1/f", i, state, pause); end
    end
    init = 1'b1; cfg_af_in = 3'd6; cfg_ae_in = 3'd1;
    step();
    init = 1'b0;
    step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL invalid_reload_exit: got %0d expected 2", state); end
    checks++; if ({cfg_af_out, cfg_ae_out} !== {3'd6, 3'd1}) begin errors++; $display("FAIL invalid_reload_thr: got %0d/%0d expected 6/1", cfg_af_out, cfg_ae_out); end
  endtask

  task automatic test_active();
    fifo_empty = 4'hB;
    step();
    checks++; if (state !== 3'd3 || active_out !== 1'b1 || idle_out !== 1'b0) begin errors++; $display("FAIL active_enter: got state=%0d act=%b idle=%b expected 3/1/0", state, active_out, idle_out); end
    fifo_almost_full = 4'h4;
    #1;
    checks++; if (pause !== 4'h0) begin errors++; $display("FAIL pause_registered: got %h expected 0", pause); end
    step();
    checks++; if (pause !== 4'h4) begin errors++; $display("FAIL pause_follow: got %h expected 4", pause); end
    fifo_empty = 4'hF;
    step();
    checks++; if (state !== 3'd2 || idle_out !== 1'b1 || active_out !== 1'b0) begin errors++; $display("FAIL active_to_idle: got state=%0d idle=%b act=%b expected 2/1/0", state, idle_out, active_out); end
    checks++; if (pause !== 4'h4) begin errors++; $display("FAIL idle_pause: got %h expected 4", pause); end
    fifo_almost_full = 4'h9;
    step();
    checks++; if (pause !== 4'h9) begin errors++; $display("FAIL idle_pause2: got %h expected 9", pause); end
    fifo_almost_full = 4'h0; fifo_empty = 4'hB;
    step();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL active_reenter: got %0d expected 3", state); end
  endtask

  task automatic test_error();
    fifo_error = 4'h2; init = 1'b1; cfg_af_in = 3'd4; cfg_ae_in = 3'd0;
    step();
    fifo_error = 4'h0; init = 1'b0;
    checks++; if (state !== 3'd4 || error_out !== 1'b1 || active_out !== 1'b0) begin errors++; $display("FAIL error_enter: got state=%0d err=%b act=%b expected 4/1/0", state, error_out, active_out); end
    checks++; if (error_lanes !== 4'h2 || pause !== 4'hF) begin errors++; $display("FAIL error_lanes_pause: got lanes=%h pause=%h expected 2/f", error_lanes, pause); end
    step();
    checks++; if (state !== 3'd4 || error_lanes !== 4'h2) begin errors++; $display("FAIL error_hold: got state=%0d lanes=%h expected 4/2", state, error_lanes); end
    fifo_error = 4'h8;
    step();
    fifo_error = 4'h0;
    checks++; if (error_lanes !== 4'hA) begin errors++; $display("FAIL error_sticky: got %h expected a", error_lanes); end
    init = 1'b1; cfg_af_in = 3'd5; cfg_ae_in = 3'd2;
    step(); step();
    init = 1'b0;
    step();
    checks++; if (state !== 3'd4 || error_out !== 1'b1) begin errors++; $display("FAIL error_ignores_init: got state=%0d err=%b expected 4/1", state, error_out); end
    checks++; if ({cfg_af_out, cfg_ae_out} !== {3'd6, 3'd1}) begin errors++; $display("FAIL error_thr_hold: got %0d/%0d expected 6/1", cfg_af_out, cfg_ae_out); end
    #2 reset = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || error_out !== 1'b0 || error_lanes !== 4'h0 || pause !== 4'hF) begin errors++; $display("FAIL error_async_clear: got state=%0d err=%b lanes=%h pause=%h expected 0/0/0/f", state, error_out, error_lanes, pause); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_async_reset();
    bit reached = 1'b0;
    fifo_empty = 4'hF;
    step();
    init = 1'b1; cfg_af_in = 3'd5; cfg_ae_in = 3'd2;
    step();
    init = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step();
      if (state === 3'd2) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL arst_bringup_timeout: got state=%0d expected 2", state); end
    fifo_empty = 4'h7;
    step();
    checks++; if (state !== 3'd3 || {cfg_af_out, cfg_ae_out} !== {3'd5, 3'd2}) begin errors++; $display("FAIL arst_active: got state=%0d thr=%0d/%0d expected 3 5/2", state, cfg_af_out, cfg_ae_out); end
    #3 reset = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || active_out !== 1'b0 || pause !== 4'hF) begin errors++; $display("FAIL arst_clear: got state=%0d act=%b pause=%h expected 0/0/f", state, active_out, pause); end
    checks++; if ({cfg_af_out, cfg_ae_out} !== {3'd6, 3'd1}) begin errors++; $display("FAIL arst_thr_default: got %0d/%0d expected 6/1", cfg_af_out, cfg_ae_out); end
    step();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_reinit();
    test_invalid_thr();
    test_active();
    test_error();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
